// File: rtl/gpio_serial_loader.sv
// Loads the GPIO pad configuration words into the two serial configuration chains,
// with a bit-bang override that hands the chain pins to software.
`timescale 1ns/1ps
module gpio_serial_loader #(
    parameter int NCHAIN   = 19,
    parameter int CFG_BITS = 13,
    parameter int CLKDIV   = 4
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic                start,
    output logic [5:0]          cfg_addr_1,
    output logic [5:0]          cfg_addr_2,
    input  logic [CFG_BITS-1:0] cfg_data_1,
    input  logic [CFG_BITS-1:0] cfg_data_2,
    input  logic                bb_en,
    input  logic                bb_clock,
    input  logic                bb_resetn,
    input  logic                bb_load,
    input  logic                bb_data_1,
    input  logic                bb_data_2,
    output logic                serial_clock,
    output logic                serial_resetn,
    output logic                serial_load,
    output logic                serial_data_1,
    output logic                serial_data_2,
    output logic                busy,
    output logic                done
);

    typedef enum logic [2:0] {IDLE, RST, FETCH, LATCH, SHIFT, LOAD, LOADLO, DONE} state_t;

    localparam logic [7:0] DIV_LAST  = 8'(CLKDIV - 1);
    localparam logic [3:0] BIT_LAST  = 4'(CFG_BITS - 1);
    localparam logic [4:0] WORD_LAST = 5'(NCHAIN - 1);

    state_t              state_q, state_d;
    logic [7:0]          div_q, div_d;
    logic [3:0]          bitcnt_q, bitcnt_d;
    logic [4:0]          wordcnt_q, wordcnt_d;
    logic                phase_q, phase_d;
    logic [CFG_BITS-1:0] sr1_q, sr1_d, sr2_q, sr2_d;

    logic       sclk_q, sclk_d, srstn_q, srstn_d, sload_q, sload_d;
    logic       sd1_q, sd1_d, sd2_q, sd2_d, busy_q, busy_d, done_q, done_d;
    logic [5:0] addr1_q, addr1_d, addr2_q, addr2_d;

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        bitcnt_d  = bitcnt_q;
        wordcnt_d = wordcnt_q;
        phase_d   = phase_q;
        sr1_d     = sr1_q;
        sr2_d     = sr2_q;
        case (state_q)
            IDLE: if (start) begin
                state_d   = RST;
                div_d     = '0;
                wordcnt_d = '0;
                phase_d   = 1'b0;
            end
            // RST spans two CLKDIV periods; phase marks the second one so div stays 8 bits
            RST: if (div_q == DIV_LAST) begin
                div_d = '0;
                if (phase_q) begin
                    state_d = FETCH;
                    phase_d = 1'b0;
                end else begin
                    phase_d = 1'b1;
                end
            end else begin
                div_d = div_q + 8'd1;
            end
            FETCH: state_d = LATCH;
            LATCH: begin
                sr1_d    = cfg_data_1;
                sr2_d    = cfg_data_2;
                bitcnt_d = '0;
                phase_d  = 1'b0;
                div_d    = '0;
                state_d  = SHIFT;
            end
            SHIFT: if (div_q == DIV_LAST) begin
                div_d = '0;
                if (!phase_q) begin
                    phase_d = 1'b1;
                end else begin
                    phase_d = 1'b0;
                    sr1_d   = {sr1_q[CFG_BITS-2:0], 1'b0};
                    sr2_d   = {sr2_q[CFG_BITS-2:0], 1'b0};
                    if (bitcnt_q == BIT_LAST) begin
                        bitcnt_d = '0;
                        if (wordcnt_q < WORD_LAST) begin
                            wordcnt_d = wordcnt_q + 5'd1;
                            state_d   = FETCH;
                        end else begin
                            state_d = LOAD;
                        end
                    end else begin
                        bitcnt_d = bitcnt_q + 4'd1;
                    end
                end
            end else begin
                div_d = div_q + 8'd1;
            end
            LOAD: if (div_q == DIV_LAST) begin
                div_d   = '0;
                state_d = LOADLO;
            end else begin
                div_d = div_q + 8'd1;
            end
            LOADLO: if (div_q == DIV_LAST) begin
                div_d   = '0;
                state_d = DONE;
            end else begin
                div_d = div_q + 8'd1;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Override aborts any transfer and blocks start in IDLE
        if (bb_en) begin
            state_d   = IDLE;
            div_d     = '0;
            bitcnt_d  = '0;
            wordcnt_d = '0;
            phase_d   = 1'b0;
        end
    end

    // Outputs are decoded from the next state so the registered pins line up with the state
    always_comb begin
        sclk_d  = (state_d == SHIFT) && phase_d;
        sd1_d   = (state_d == SHIFT) ? sr1_d[CFG_BITS-1] : 1'b0;
        sd2_d   = (state_d == SHIFT) ? sr2_d[CFG_BITS-1] : 1'b0;
        sload_d = (state_d == LOAD);
        srstn_d = (state_d != RST);
        busy_d  = (state_d != IDLE);
        done_d  = (state_d == DONE);
        addr1_d = addr1_q;
        addr2_d = addr2_q;
        if (state_d == FETCH) begin
            addr1_d = 6'(NCHAIN - 1) - {1'b0, wordcnt_d};
            addr2_d = 6'(NCHAIN) + {1'b0, wordcnt_d};
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q   <= IDLE;
            div_q     <= '0;
            bitcnt_q  <= '0;
            wordcnt_q <= '0;
            phase_q   <= 1'b0;
            sr1_q     <= '0;
            sr2_q     <= '0;
            sclk_q    <= 1'b0;
            srstn_q   <= 1'b0;
            sload_q   <= 1'b0;
            sd1_q     <= 1'b0;
            sd2_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            addr1_q   <= '0;
            addr2_q   <= '0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            bitcnt_q  <= bitcnt_d;
            wordcnt_q <= wordcnt_d;
            phase_q   <= phase_d;
            sr1_q     <= sr1_d;
            sr2_q     <= sr2_d;
            sclk_q    <= sclk_d;
            srstn_q   <= srstn_d;
            sload_q   <= sload_d;
            sd1_q     <= sd1_d;
            sd2_q     <= sd2_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            addr1_q   <= addr1_d;
            addr2_q   <= addr2_d;
        end
    end

    assign serial_clock  = bb_en ? bb_clock  : sclk_q;
    assign serial_resetn = bb_en ? bb_resetn : srstn_q;
    assign serial_load   = bb_en ? bb_load   : sload_q;
    assign serial_data_1 = bb_en ? bb_data_1 : sd1_q;
    assign serial_data_2 = bb_en ? bb_data_2 : sd2_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign cfg_addr_1    = addr1_q;
    assign cfg_addr_2    = addr2_q;

endmodule

// File: tb/tb_gpio_serial_loader.sv
// Directed bench for gpio_serial_loader: reset, full transfer, bit-bang abort,
// mid-transfer reset and start collisions, against a synchronous-read register file.
`timescale 1ns/1ps
module tb_gpio_serial_loader;
    localparam int CLKDIV = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [5:0]  cfg_addr_1, cfg_addr_2;
    logic [12:0] rd1 = '0, rd2 = '0;
    logic        bb_en = 1'b0, bb_clock = 1'b0, bb_resetn = 1'b0, bb_load = 1'b0;
    logic        bb_data_1 = 1'b0, bb_data_2 = 1'b0;
    logic        serial_clock, serial_resetn, serial_load, serial_data_1, serial_data_2;
    logic        busy, done;

    int total = 0;
    int bad = 0;

    logic [12:0] mem [0:63];

    logic [12:0] first1, first2, last1, last2;
    logic [5:0]  a1_first, a2_first, a1_last, a2_last;
    int          setup_err, load_err, done_cnt, busy_after_bb;
    logic        busy_c1, rstn_c1;
    logic        bbo_clk, bbo_rstn, bbo_load, bbo_d1, bbo_d2, bb_busy_next;
    logic        rst_busy0, rst_busy1, rst_rstn1, rst_clk1, rst_rstn2;
    logic [5:0]  rst_a1;

    gpio_serial_loader #(.NCHAIN(19), .CFG_BITS(13), .CLKDIV(CLKDIV)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .start(start),
        .cfg_addr_1(cfg_addr_1), .cfg_addr_2(cfg_addr_2),
        .cfg_data_1(rd1), .cfg_data_2(rd2),
        .bb_en(bb_en), .bb_clock(bb_clock), .bb_resetn(bb_resetn), .bb_load(bb_load),
        .bb_data_1(bb_data_1), .bb_data_2(bb_data_2),
        .serial_clock(serial_clock), .serial_resetn(serial_resetn), .serial_load(serial_load),
        .serial_data_1(serial_data_1), .serial_data_2(serial_data_2),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        rd1 <= mem[cfg_addr_1];
        rd2 <= mem[cfg_addr_2];
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, required finish before 1ms");
        $fatal(1);
    end

    // Starts a transfer (caller sits just after a posedge) and records observations per cycle.
    // Cycle 1 is the cycle after the edge that samples start.
    task automatic run_xfer(input int bb_at, input int rst_at, input bit collide,
                            input int limit, output int done_cyc, output int rises);
        int cyc, nbit, stab1, stab2;
        logic pc, pd1, pd2;
        done_cyc = 0; rises = 0; nbit = 0; stab1 = 0; stab2 = 0;
        setup_err = 0; load_err = 0; done_cnt = 0; busy_after_bb = 0;
        pc = 1'b0; pd1 = 1'b0; pd2 = 1'b0;
        first1 = '0; first2 = '0; last1 = '0; last2 = '0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        while (cyc <= limit) begin
            if (bb_at > 0 && cyc == bb_at) begin
                bb_en = 1'b1; bb_clock = 1'b1; bb_data_2 = 1'b1;
                bb_resetn = 1'b1; bb_data_1 = 1'b0; bb_load = 1'b0;
                #1;
                bbo_clk = serial_clock; bbo_rstn = serial_resetn; bbo_load = serial_load;
                bbo_d1 = serial_data_1; bbo_d2 = serial_data_2;
            end
            if (bb_at > 0 && cyc == bb_at + 3) start = 1'b1;
            if (bb_at > 0 && cyc == bb_at + 10) begin
                bb_en = 1'b0; bb_clock = 1'b0; bb_data_2 = 1'b0; bb_resetn = 1'b0;
            end
            if (collide && cyc == 100) start = 1'b1;
            if (rst_at > 0 && cyc == rst_at) rst = 1'b1;
            @(negedge clk);
            if (cyc == 1) begin busy_c1 = busy; rstn_c1 = serial_resetn; end
            if (cyc == 2*CLKDIV + 1) begin a1_first = cfg_addr_1; a2_first = cfg_addr_2; end
            if (cyc == 2*CLKDIV + 1 + 18*(2 + 26*CLKDIV)) begin
                a1_last = cfg_addr_1; a2_last = cfg_addr_2;
            end
            if (rst_at > 0 && cyc == rst_at) rst_busy0 = busy;
            if (rst_at > 0 && cyc == rst_at + 1) begin
                rst_busy1 = busy; rst_rstn1 = serial_resetn; rst_clk1 = serial_clock; rst_a1 = cfg_addr_1;
            end
            if (rst_at > 0 && cyc == rst_at + 2) rst_rstn2 = serial_resetn;
            if (bb_at > 0 && cyc == bb_at + 1) bb_busy_next = busy;
            if (bb_at > 0 && cyc > bb_at && busy) busy_after_bb++;
            if (!bb_en) begin
                stab1 = (serial_data_1 === pd1) ? stab1 + 1 : 1;
                stab2 = (serial_data_2 === pd2) ? stab2 + 1 : 1;
                if (serial_clock && !pc) begin
                    rises++;
                    if (stab1 < CLKDIV + 1 || stab2 < CLKDIV + 1) setup_err++;
                    if (nbit < 13) begin
                        first1 = {first1[11:0], serial_data_1};
                        first2 = {first2[11:0], serial_data_2};
                    end
                    last1 = {last1[11:0], serial_data_1};
                    last2 = {last2[11:0], serial_data_2};
                    nbit++;
                end
                if (serial_load && serial_clock) load_err++;
            end
            pc = serial_clock; pd1 = serial_data_1; pd2 = serial_data_2;
            if (done) begin
                done_cnt++;
                if (done_cyc == 0) done_cyc = cyc;
                if (collide) start = 1'b1;
                break;
            end
            @(posedge clk); #1;
            start = 1'b0;
            rst = 1'b0;
            cyc++;
        end
        @(posedge clk); #1;
        start = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        @(negedge clk);
        total++; if (serial_clock !== 1'b0) begin bad++; $display("FAIL rst_sclk got=%b exp=0", serial_clock); end
        total++; if (serial_resetn !== 1'b0) begin bad++; $display("FAIL rst_srstn got=%b exp=0", serial_resetn); end
        total++; if (serial_load !== 1'b0) begin bad++; $display("FAIL rst_sload got=%b exp=0", serial_load); end
        total++; if ({serial_data_1, serial_data_2} !== 2'b00) begin bad++; $display("FAIL rst_sdata got=%b%b exp=00", serial_data_1, serial_data_2); end
        total++; if ({busy, done} !== 2'b00) begin bad++; $display("FAIL rst_busy_done got=%b%b exp=00", busy, done); end
        total++; if ({cfg_addr_1, cfg_addr_2} !== 12'h000) begin bad++; $display("FAIL rst_addr got=%0d,%0d exp=0,0", cfg_addr_1, cfg_addr_2); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        total++; if (serial_resetn !== 1'b1) begin bad++; $display("FAIL rst_release_srstn got=%b exp=1", serial_resetn); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_release_busy got=%b exp=0", busy); end
        @(posedge clk); #1;
    endtask

    task automatic test_full_transfer();
        int dc, r;
        run_xfer(0, 0, 0, 2300, dc, r);
        total++; if (busy_c1 !== 1'b1) begin bad++; $display("FAIL full_busy_c1 got=%b exp=1", busy_c1); end
        total++; if (rstn_c1 !== 1'b0) begin bad++; $display("FAIL full_srstn_c1 got=%b exp=0", rstn_c1); end
        total++; if (dc !== 2031) begin bad++; $display("FAIL full_done_cycle got=%0d exp=2031", dc); end
        total++; if (r !== 247) begin bad++; $display("FAIL full_rises got=%0d exp=247", r); end
        total++; if (first1 !== 13'd18) begin bad++; $display("FAIL full_first1 got=%h exp=0012", first1); end
        total++; if (first2 !== 13'd19) begin bad++; $display("FAIL full_first2 got=%h exp=0013", first2); end
        total++; if (last1 !== 13'b1100000001001) begin bad++; $display("FAIL full_last1 got=%b exp=1100000001001", last1); end
        total++; if (last2 !== 13'h1809) begin bad++; $display("FAIL full_last2 got=%h exp=1809", last2); end
        total++; if ({a1_first, a2_first} !== {6'd18, 6'd19}) begin bad++; $display("FAIL full_addr_first got=%0d,%0d exp=18,19", a1_first, a2_first); end
        total++; if ({a1_last, a2_last} !== {6'd0, 6'd37}) begin bad++; $display("FAIL full_addr_last got=%0d,%0d exp=0,37", a1_last, a2_last); end
        total++; if (setup_err !== 0) begin bad++; $display("FAIL full_setup got=%0d violations exp=0", setup_err); end
        total++; if (load_err !== 0) begin bad++; $display("FAIL full_load_vs_clk got=%0d violations exp=0", load_err); end
        @(negedge clk);
        total++; if ({busy, done} !== 2'b00) begin bad++; $display("FAIL full_after_done got=busy%b done%b exp=busy0 done0", busy, done); end
        @(posedge clk); #1;
    endtask

    task automatic test_bitbang_abort();
        int dc, r;
        run_xfer(500, 0, 0, 2300, dc, r);
        total++; if ({bbo_clk, bbo_d2, bbo_d1} !== 3'b110) begin bad++; $display("FAIL bb_follow got=clk%b d2%b d1%b exp=clk1 d21 d10", bbo_clk, bbo_d2, bbo_d1); end
        total++; if ({bbo_rstn, bbo_load} !== 2'b10) begin bad++; $display("FAIL bb_follow_rl got=rstn%b load%b exp=rstn1 load0", bbo_rstn, bbo_load); end
        total++; if (bb_busy_next !== 1'b0) begin bad++; $display("FAIL bb_busy_next got=%b exp=0", bb_busy_next); end
        total++; if (busy_after_bb !== 0) begin bad++; $display("FAIL bb_no_restart got=%0d busy cycles exp=0", busy_after_bb); end
        total++; if (done_cnt !== 0) begin bad++; $display("FAIL bb_no_done got=%0d exp=0", done_cnt); end
        run_xfer(0, 0, 0, 2300, dc, r);
        total++; if (dc !== 2031) begin bad++; $display("FAIL bb_recover_done got=%0d exp=2031", dc); end
        total++; if (r !== 247) begin bad++; $display("FAIL bb_recover_rises got=%0d exp=247", r); end
        @(posedge clk); #1;
    endtask

    task automatic test_mid_reset();
        int dc, r;
        run_xfer(0, 800, 0, 1200, dc, r);
        total++; if (rst_busy0 !== 1'b1) begin bad++; $display("FAIL mrst_busy_before got=%b exp=1", rst_busy0); end
        total++; if ({rst_busy1, rst_rstn1, rst_clk1} !== 3'b000) begin bad++; $display("FAIL mrst_outputs got=busy%b rstn%b clk%b exp=000", rst_busy1, rst_rstn1, rst_clk1); end
        total++; if (rst_a1 !== 6'd0) begin bad++; $display("FAIL mrst_addr got=%0d exp=0", rst_a1); end
        total++; if (rst_rstn2 !== 1'b1) begin bad++; $display("FAIL mrst_srstn_after got=%b exp=1", rst_rstn2); end
        total++; if (done_cnt !== 0) begin bad++; $display("FAIL mrst_no_done got=%0d exp=0", done_cnt); end
    endtask

    task automatic test_start_collision();
        int dc, r;
        run_xfer(0, 0, 1, 2300, dc, r);
        total++; if (dc !== 2031) begin bad++; $display("FAIL coll_done_cycle got=%0d exp=2031", dc); end
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL coll_done_plus1 got=%b exp=0", busy); end
        @(posedge clk); #1;
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL coll_done_plus2 got=%b exp=0", busy); end
        run_xfer(0, 0, 0, 2300, dc, r);
        total++; if (dc !== 2031) begin bad++; $display("FAIL coll_restart_done got=%0d exp=2031", dc); end
        total++; if (r !== 247) begin bad++; $display("FAIL coll_restart_rises got=%0d exp=247", r); end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 13'(i);
        mem[0]  = 13'h1809;
        mem[37] = 13'h1809;
        test_reset();
        test_full_transfer();
        test_bitbang_abort();
        test_mid_reset();
        test_start_collision();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/gpio_serial_loader.md
# gpio_serial_loader

Sequencer in the housekeeping block that loads the 13-bit GPIO pad configuration words into the two serial configuration chains: user 1 (GPIO 0–18) and user 2 (GPIO 19–37). It fetches the words from the housekeeping configuration register file and shifts them out MSB-first on a divided serial clock. It then pulses the load strobe. A bit-bang override hands the serial pins to the SPI bit-bang register and aborts any transfer in progress.

## Interface

Parameters:

- `NCHAIN`, 19: GPIO blocks per chain.
- `CFG_BITS`, 13: bits per configuration word.
- `CLKDIV`, 4: `wb_clk_i` cycles per serial clock phase. Legal range 1–255.

Ports:

- `wb_clk_i`  in  1  system clock; the only clock.
- `wb_rst_i`  in  1  synchronous, active-high reset.
- `start`  in  1  single-cycle transfer request. Honoured only in IDLE with `bb_en`=0.
- `cfg_addr_1`  out  6  register-file address for the chain 1 word (GPIO index 0–18).
- `cfg_addr_2`  out  6  register-file address for the chain 2 word (GPIO index 19–37).
- `cfg_data_1`, `cfg_data_2`  in  `CFG_BITS` each  read data. Valid on the cycle after the address is presented (synchronous read).
- `bb_en`  in  1  bit-bang override enable.
- `bb_clock`, `bb_resetn`, `bb_load`, `bb_data_1`, `bb_data_2`  in  1 each  bit-bang pin values.
- `serial_clock`, `serial_resetn`, `serial_load`, `serial_data_1`, `serial_data_2`  out  1 each  chain pins.
- `busy`  out  1  high from the cycle after `start` is accepted until the cycle after `done`.
- `done`  out  1  one-cycle pulse when a transfer completes. Not asserted on abort.

## Operation

- States: IDLE, RST, FETCH, LATCH, SHIFT, LOAD, LOADLO, DONE.
- Counters:
  - `div`: 8 bits, counts `CLKDIV` cycles.
  - `bitcnt`: 4 bits, counts 0–12.
  - `wordcnt`: 5 bits, counts 0–18.
  - `phase`: 1 bit, 0 = clock low, 1 = clock high.
- IDLE, on `start`=1 and `bb_en`=0: go to RST with `div`=0 and `wordcnt`=0.
- RST:
  - `serial_resetn`=0, `serial_clock`=0 for 2·`CLKDIV` cycles.
  - Then go to FETCH.
- FETCH (1 cycle): drive `cfg_addr_1` = 18−`wordcnt` and `cfg_addr_2` = 19+`wordcnt`. The first word shifted ends up in the block farthest from the chain head.
- LATCH (1 cycle):
  - Capture `cfg_data_1` and `cfg_data_2` into two 13-bit shift registers.
  - Clear `bitcnt`, `phase`, and `div`.
- SHIFT:
  - `serial_data_n` = shift register bit 12, so data goes out MSB first.
  - Low phase: `serial_clock`=0 for `CLKDIV` cycles.
  - High phase: `serial_clock`=1 for `CLKDIV` cycles.
  - At the end of the high phase, shift both registers left by 1 and increment `bitcnt`.
  - After bit 12: if `wordcnt`<18, increment `wordcnt` and go to FETCH; else go to LOAD.
- LOAD: `serial_load`=1 for `CLKDIV` cycles, then LOADLO.
- LOADLO: `serial_load`=0 for `CLKDIV` cycles, then DONE.
- DONE: `done`=1 for 1 cycle, then IDLE.
- Data changes only while `serial_clock`=0. The chain samples on the rising edge.
- Per transfer: 247 rising `serial_clock` edges and 1 `serial_load` pulse.
- Override:
  - While `bb_en`=1, every `serial_*` output equals its `bb_*` input, combinationally muxed after the registered FSM outputs.
  - `bb_en`=1 in any non-IDLE state forces IDLE on the next edge, with `busy`=0 and no `done`.
- `start` while busy: ignored, not queued.
- `wb_rst_i`=1 in any state: on the next edge, state=IDLE and all counters=0.

## Timing

- Reset values (FSM outputs):
  - `serial_clock`=0, `serial_resetn`=0, `serial_load`=0, `serial_data_1`/`serial_data_2`=0.
  - `busy`=0, `done`=0.
  - `cfg_addr_1`/`cfg_addr_2`=0.
- `serial_resetn` goes to 1 on the first IDLE cycle after reset release and stays 1 except in RST.
- All FSM outputs are registered. Only the bit-bang mux is combinational.
- Latency, with `start` sampled at edge 0:
  - `busy`=1 from cycle 1.
  - RST occupies cycles 1 … 2·`CLKDIV`.
  - Each word takes 2 + 26·`CLKDIV` cycles.
  - LOAD + LOADLO take 2·`CLKDIV` cycles.
  - `done` is high in cycle 4·`CLKDIV` + 19·(2+26·`CLKDIV`) + 1. For `CLKDIV`=4 this is cycle 2031.
  - `busy` falls in the cycle after `done`.
- A `start` arriving in the same cycle as `done`, or in the first IDLE cycle after it, is honoured in IDLE only.
- Reset has priority over `start` and `bb_en`. `bb_en` has priority over `start`.

## Test plan

- Reset check:
  - Stimulus: assert `wb_rst_i` for 2 cycles, then release.
  - Required: all outputs at their reset values; `serial_resetn`=1 one cycle after release; `busy`=0.
- Full transfer:
  - Stimulus: `CLKDIV`=4; register file holds word 0x1809 at index 0 and 37, and index value for all others.
  - Required: `done` at cycle 2031 and 247 `serial_clock` rising edges.
  - Required: the last 13 bits on `serial_data_1` are 1,1,0,0,0,0,0,0,0,1,0,0,1.
  - Required: the first address pair is (18,19) and the last is (0,37).
- Setup ordering: on every `serial_clock` rising edge, `serial_data_n` has been stable for ≥ `CLKDIV` cycles; `serial_load` is never high while `serial_clock`=1.
- Bit-bang abort:
  - Stimulus: raise `bb_en` at cycle 500 and drive `bb_clock`=1, `bb_data_2`=1.
  - Required: outputs follow the `bb_*` inputs in the same cycle; `busy`=0 next cycle; `done` never asserted.
  - Required: after `bb_en`=0, a new `start` performs a complete transfer.
- Mid-transfer reset: assert `wb_rst_i` during SHIFT of word 7 → IDLE next edge, `serial_resetn`=0, no `done`.
- Start collisions: pulse `start` at cycle 100 and again in the `done` cycle → neither pulse starts a transfer; a `start` 2 cycles after `done` starts a transfer normally.
